// File: rtl/uart_rx_fsm.sv
// UART receiver frame controller: sequences start/data/parity/stop bits and drives counters and enables.
// Optional per-error pulse outputs par_err_o/stp_err_o when UART_RX_FSM_ERR_FLAGS_EN is defined.
module uart_rx_fsm #(
   parameter int unsigned PRESCALE   = 8,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       RX_IN,
   input  logic       PAR_EN,
   input  logic       strt_glitch,
   input  logic       par_err,
   input  logic       stp_err,
   output logic [4:0] edge_cnt,
   output logic [3:0] bit_cnt,
   output logic       dat_samp_en,
   output logic       deser_en,
   output logic       strt_chk_en,
   output logic       par_chk_en,
   output logic       stp_chk_en,
   output logic       data_valid
`ifdef UART_RX_FSM_ERR_FLAGS_EN
   ,
   output logic       par_err_o,
   output logic       stp_err_o
`endif
);

   localparam int unsigned EDGE_W = 5;
   localparam int unsigned BIT_W  = 4;
   localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(PRESCALE - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic [EDGE_W-1:0]   edge_q, edge_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                par_en_q, par_en_d;
   logic                err_q, err_d;
   logic                bit_end;

   logic dat_samp_en_q, dat_samp_en_d;
   logic deser_en_q, deser_en_d;
   logic strt_chk_en_q, strt_chk_en_d;
   logic par_chk_en_q, par_chk_en_d;
   logic stp_chk_en_q, stp_chk_en_d;
   logic data_valid_q, data_valid_d;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
   logic par_flag_q, par_flag_d;
   logic stp_flag_q, stp_flag_d;
`endif

   assign bit_end = (edge_q == EDGE_LAST);

   // State, counter and registered-output flops
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q       <= IDLE;
         edge_q        <= '0;
         bit_q         <= '0;
         par_en_q      <= 1'b0;
         err_q         <= 1'b0;
         dat_samp_en_q <= 1'b0;
         deser_en_q    <= 1'b0;
         strt_chk_en_q <= 1'b0;
         par_chk_en_q  <= 1'b0;
         stp_chk_en_q  <= 1'b0;
         data_valid_q  <= 1'b0;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
         par_flag_q    <= 1'b0;
         stp_flag_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         edge_q        <= edge_d;
         bit_q         <= bit_d;
         par_en_q      <= par_en_d;
         err_q         <= err_d;
         dat_samp_en_q <= dat_samp_en_d;
         deser_en_q    <= deser_en_d;
         strt_chk_en_q <= strt_chk_en_d;
         par_chk_en_q  <= par_chk_en_d;
         stp_chk_en_q  <= stp_chk_en_d;
         data_valid_q  <= data_valid_d;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
         par_flag_q    <= par_flag_d;
         stp_flag_q    <= stp_flag_d;
`endif
      end
   end

   // Next state and bit timing; checker inputs are only looked at on their bit end
   always_comb begin
      state_d  = state_q;
      edge_d   = bit_end ? '0 : edge_q + EDGE_W'(1);
      bit_d    = bit_end ? bit_q + BIT_W'(1) : bit_q;
      par_en_d = par_en_q;
      err_d    = err_q;
      unique case (state_q)
         IDLE: begin
            edge_d = '0;
            bit_d  = '0;
            if (!RX_IN) begin
               state_d  = START;
               par_en_d = PAR_EN;
            end
         end
         START: begin
            if (bit_end) begin
               if (strt_glitch) begin
                  state_d = IDLE;
                  bit_d   = '0;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (bit_end && (bit_q == BIT_LAST)) begin
               state_d = par_en_q ? PARITY : STOP;
            end
         end
         PARITY: begin
            if (bit_end) begin
               err_d   = par_err;
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               bit_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
            edge_d  = '0;
            bit_d   = '0;
         end
      endcase
   end

   // Output decode, registered so each enable lines up with the state it describes
   always_comb begin
      dat_samp_en_d = (state_d != IDLE);
      deser_en_d    = (state_d == DATA);
      strt_chk_en_d = (state_d == START)  && (edge_d == EDGE_LAST);
      par_chk_en_d  = (state_d == PARITY) && (edge_d == EDGE_LAST);
      stp_chk_en_d  = (state_d == STOP)   && (edge_d == EDGE_LAST);
      data_valid_d  = (state_q == STOP) && bit_end && !(err_q | stp_err);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
      par_flag_d    = (state_q == STOP) && bit_end && err_q;
      stp_flag_d    = (state_q == STOP) && bit_end && stp_err;
`endif
   end

   assign edge_cnt    = edge_q;
   assign bit_cnt     = bit_q;
   assign dat_samp_en = dat_samp_en_q;
   assign deser_en    = deser_en_q;
   assign strt_chk_en = strt_chk_en_q;
   assign par_chk_en  = par_chk_en_q;
   assign stp_chk_en  = stp_chk_en_q;
   assign data_valid  = data_valid_q;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
   assign par_err_o   = par_flag_q;
   assign stp_err_o   = stp_flag_q;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm (PRESCALE=8, DATA_WIDTH=8); cycle n counts edges after the start-edge detection edge.
// Error-flag ports are exercised when UART_RX_FSM_ERR_FLAGS_EN is defined.
module tb_uart_rx_fsm;

   logic       CLK = 1'b0;
   logic       RST;
   logic       RX_IN;
   logic       PAR_EN;
   logic       strt_glitch;
   logic       par_err;
   logic       stp_err;
   logic [4:0] edge_cnt;
   logic [3:0] bit_cnt;
   logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en, data_valid;
`ifdef UART_RX_FSM_ERR_FLAGS_EN
   logic       par_err_o, stp_err_o;
`endif

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_dv_cyc = -1;

   uart_rx_fsm #(.PRESCALE(8), .DATA_WIDTH(8)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .PAR_EN      (PAR_EN),
      .strt_glitch (strt_glitch),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .dat_samp_en (dat_samp_en),
      .deser_en    (deser_en),
      .strt_chk_en (strt_chk_en),
      .par_chk_en  (par_chk_en),
      .stp_chk_en  (stp_chk_en),
      .data_valid  (data_valid)
`ifdef UART_RX_FSM_ERR_FLAGS_EN
      ,
      .par_err_o   (par_err_o),
      .stp_err_o   (stp_err_o)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic line_bit(input logic [7:0] d, input logic pe, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return d[idx-1];
      if (idx == 9 && pe) return ^d;
      return 1'b1;
   endfunction

   // Idle line; data_valid must not linger and the FSM must stay in IDLE
   task automatic idle(input string tag, input int cycles);
      RX_IN = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         tick();
         chk({tag, ":idle_dv"}, 32'(data_valid), 32'd0);
         chk({tag, ":idle_samp"}, 32'(dat_samp_en), 32'd0);
      end
   endtask

   // One frame; checker inputs carry 1 outside their check cycles, PAR_EN flips after the start
   task automatic frame(input string tag, input logic [7:0] d, input logic pe, input logic glitch,
                        input logic perr, input logic serr, input logic exp_dv);
      int last, deser_n, dv_n, dv_at, sck_n, pck_n, tck_n;
      logic exp_pf, exp_sf;
      last    = glitch ? 8 : (pe ? 88 : 80);
      deser_n = 0; dv_n = 0; dv_at = -1; sck_n = 0; pck_n = 0; tck_n = 0;
      exp_pf  = pe & perr & ~glitch;
      exp_sf  = serr & ~glitch;
      RX_IN   = 1'b0;
      PAR_EN  = pe;
      tick();
      for (int n = 0; n <= last; n++) begin
         if (deser_en)    deser_n++;
         if (strt_chk_en) sck_n++;
         if (par_chk_en)  pck_n++;
         if (stp_chk_en)  tck_n++;
         if (data_valid) begin
            dv_n++;
            dv_at = n;
            last_dv_cyc = cyc;
         end
         if (n == 0) begin
            chk({tag, ":n0_edge"}, 32'(edge_cnt), 32'd0);
            chk({tag, ":n0_bit"}, 32'(bit_cnt), 32'd0);
            chk({tag, ":n0_samp"}, 32'(dat_samp_en), 32'd1);
            chk({tag, ":n0_dv"}, 32'(data_valid), 32'd0);
         end
         if (n == 7) begin
            chk({tag, ":strt_chk"}, 32'(strt_chk_en), 32'd1);
            chk({tag, ":n7_edge"}, 32'(edge_cnt), 32'd7);
         end
         if (!glitch && n == 8) begin
            chk({tag, ":data_deser"}, 32'(deser_en), 32'd1);
            chk({tag, ":data_bit"}, 32'(bit_cnt), 32'd1);
         end
         if (!glitch && pe && n == 79) begin
            chk({tag, ":par_chk"}, 32'(par_chk_en), 32'd1);
            chk({tag, ":par_bit"}, 32'(bit_cnt), 32'd9);
         end
         if (!glitch && n == last - 1) begin
            chk({tag, ":stp_chk"}, 32'(stp_chk_en), 32'd1);
            chk({tag, ":stp_bit"}, 32'(bit_cnt), pe ? 32'd10 : 32'd9);
         end
         if (n == last) begin
            chk({tag, ":end_samp"}, 32'(dat_samp_en), 32'd0);
            chk({tag, ":end_edge"}, 32'(edge_cnt), 32'd0);
            chk({tag, ":end_bit"}, 32'(bit_cnt), 32'd0);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
            chk({tag, ":par_err_o"}, 32'(par_err_o), 32'(exp_pf));
            chk({tag, ":stp_err_o"}, 32'(stp_err_o), 32'(exp_sf));
`endif
         end
         RX_IN       = glitch ? logic'(n >= 2) : line_bit(d, pe, (n + 1) / 8);
         PAR_EN      = ~pe;
         strt_glitch = (n == 7) ? glitch : 1'b1;
         par_err     = (pe && n == 79) ? perr : 1'b1;
         stp_err     = (n == last - 1) ? serr : 1'b1;
         if (n < last) tick();
      end
      chk({tag, ":deser_cycles"}, 32'(deser_n), glitch ? 32'd0 : 32'd64);
      chk({tag, ":strt_chk_cycles"}, 32'(sck_n), 32'd1);
      chk({tag, ":par_chk_cycles"}, 32'(pck_n), (pe && !glitch) ? 32'd1 : 32'd0);
      chk({tag, ":stp_chk_cycles"}, 32'(tck_n), glitch ? 32'd0 : 32'd1);
      chk({tag, ":dv_count"}, 32'(dv_n), 32'(exp_dv));
      if (exp_dv) chk({tag, ":dv_cycle"}, 32'(dv_at), 32'(last));
   endtask

   initial begin
      int t1;
      RST = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0;
      strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
      tick(); tick();
      chk("reset_outputs", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                par_chk_en, stp_chk_en, data_valid}), 32'd0);
`ifdef UART_RX_FSM_ERR_FLAGS_EN
      chk("reset_flags", 32'({par_err_o, stp_err_o}), 32'd0);
`endif
      RST = 1'b1;
      idle("pre", 3);

      frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("t1", 2);
      frame("t2_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("t2", 2);
      frame("t2_perr", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      idle("t2b", 2);
      frame("t3_glitch", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      idle("t3", 2);
      frame("t4_stperr", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle("t4", 2);

      // Reset asserted mid-frame at data bit 4
      RX_IN = 1'b0; strt_glitch = 1'b0;
      tick();
      for (int n = 1; n <= 35; n++) begin
         RX_IN = 1'b1;
         tick();
      end
      chk("t5_pre_bit", 32'(bit_cnt), 32'd4);
      chk("t5_pre_deser", 32'(deser_en), 32'd1);
      #2 RST = 1'b0;
      #1;
      chk("t5_async_clear", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, strt_chk_en,
                                 par_chk_en, stp_chk_en, data_valid}), 32'd0);
      RX_IN = 1'b0;
      tick(); tick(); tick();
      chk("t5_held", 32'({edge_cnt, bit_cnt, dat_samp_en, deser_en, data_valid}), 32'd0);
      RX_IN = 1'b1;
      #2 RST = 1'b1;
      idle("t5", 3);
      frame("t5_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      idle("t5b", 2);

      // Back-to-back: second start edge sampled in the single IDLE cycle after STOP
      frame("t6_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      t1 = last_dv_cyc;
      frame("t6_aa", 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("t6_gap", 32'(last_dv_cyc - t1), 32'd81);
      idle("t6", 4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
